// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and address-mux select constants shared by the memory port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY} state_e;
   localparam logic ADDR_SEL_IF = 1'b0;
   localparam logic ADDR_SEL_LS = 1'b1;
endpackage

// File: rtl/mem_port_arb_n_mux2by1.sv
// n_mux2by1: N-bit two-input multiplexer, y = sel ? b : a.
module n_mux2by1 #(
   parameter int N = 1
) (
   input  logic         sel,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);
   assign y = sel ? b : a;
endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates fetch and load/store requests onto one single-ported memory.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed ls priority.
module mem_port_arb
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic          ls_gnt,
   output logic          ls_rvalid,
   output logic [DW-1:0] ls_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata,
   output logic          addr_sel,
   output logic          stall_if
);
   state_e        state_q;
   logic [AW-1:0] if_addr_q, ls_addr_q;
   logic [DW-1:0] wdata_q, if_rdata_q, ls_rdata_q;
   logic          we_q, if_rvalid_q, ls_rvalid_q, ls_pri, idle;
   assign idle = (state_q == IDLE) & ~rst;
`ifdef MEM_ARB_RR_EN
   // last_ls_q: previous winner was load/store, so fetch wins the next tie
   logic last_ls_q, last_ls_d;
   assign ls_pri    = ~last_ls_q;
   assign last_ls_d = ls_gnt ? 1'b1 : if_gnt ? 1'b0 : last_ls_q;
   always_ff @(posedge clk) last_ls_q <= rst ? 1'b0 : last_ls_d;
`else
   assign ls_pri = 1'b1;
`endif
   assign ls_gnt    = idle & ls_req & (~if_req | ls_pri);
   assign if_gnt    = idle & if_req & ~ls_gnt;
   assign stall_if  = if_req & ~if_gnt;
   assign mem_en    = (state_q != IDLE);
   assign addr_sel  = (state_q == LS_BUSY) ? ADDR_SEL_LS : ADDR_SEL_IF;
   assign mem_we    = (state_q == LS_BUSY) & we_q;
   assign mem_wdata = wdata_q;
   assign if_rvalid = if_rvalid_q;
   assign ls_rvalid = ls_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;
   n_mux2by1 #(.N(AW)) u_addr_mux (
      .sel(addr_sel),
      .a  (if_addr_q),
      .b  (ls_addr_q),
      .y  (mem_addr)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         if_addr_q   <= '0;
         ls_addr_q   <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         case (state_q)
            IDLE:
               if (ls_gnt) begin
                  state_q   <= LS_BUSY;
                  ls_addr_q <= ls_addr;
                  we_q      <= ls_we;
                  wdata_q   <= ls_wdata;
               end else if (if_gnt) begin
                  state_q   <= IF_BUSY;
                  if_addr_q <= if_addr;
                  we_q      <= 1'b0;
               end
            IF_BUSY:
               if (mem_ready) begin
                  state_q     <= IDLE;
                  if_rvalid_q <= 1'b1;
                  if_rdata_q  <= mem_rdata;
               end
            LS_BUSY:
               if (mem_ready) begin
                  state_q     <= IDLE;
                  ls_rvalid_q <= 1'b1;
                  ls_rdata_q  <= we_q ? '0 : mem_rdata;
               end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed vector table, corner sequences and random traffic against a transaction-level model.
module tb_mem_port_arb;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
   localparam bit RR_ON = 1'b1;
`else
   localparam bit RR_ON = 1'b0;
`endif
   logic          clk = 1'b0, rst = 1'b1;
   logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_ready = 1'b0;
   logic [AW-1:0] if_addr = '0, ls_addr = '0;
   logic [DW-1:0] ls_wdata = '0, mem_rdata = '0;
   logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, addr_sel, stall_if;
   logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   always #5 clk = ~clk;
   mem_port_arb #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .addr_sel(addr_sel), .stall_if(stall_if)
   );
   int total = 0, passed = 0;
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask
   // transaction-level model: one in-flight access record plus the pending response
   bit            m_busy, m_ls, m_we, m_irv, m_lrv, m_last_ls;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   function automatic bit m_ls_wins();
      return ls_req && (!if_req || !RR_ON || !m_last_ls);
   endfunction
   task automatic model_check();
      bit free, e_ls, e_if;
      free = !m_busy && !rst;
      e_ls = free && m_ls_wins();
      e_if = free && if_req && !e_ls;
      chk("ls_gnt", ls_gnt, e_ls);
      chk("if_gnt", if_gnt, e_if);
      chk("stall_if", stall_if, if_req && !e_if);
      chk("mem_en", mem_en, m_busy);
      chk("mem_we", mem_we, m_busy && m_ls && m_we);
      chk("addr_sel", addr_sel, m_busy && m_ls);
      chk("if_rvalid", if_rvalid, m_irv);
      chk("ls_rvalid", ls_rvalid, m_lrv);
      if (m_busy) chk("mem_addr", mem_addr, m_addr);
      if (m_busy && m_ls && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      if (m_irv) chk("if_rdata", if_rdata, m_rdata);
      if (m_lrv) chk("ls_rdata", ls_rdata, m_rdata);
   endtask
   task automatic model_update();
      bit g_ls, g_if;
      g_ls = !m_busy && m_ls_wins();
      g_if = !m_busy && if_req && !g_ls;
      m_irv = 0;
      m_lrv = 0;
      if (rst) begin
         m_busy = 0;
         m_last_ls = 0;
      end else if (m_busy) begin
         if (mem_ready) begin
            m_busy  = 0;
            m_rdata = (m_ls && m_we) ? '0 : mem_rdata;
            if (m_ls) m_lrv = 1;
            else m_irv = 1;
         end
      end else if (g_ls) begin
         {m_busy, m_ls, m_we, m_addr, m_wdata, m_last_ls} = {2'b11, ls_we, ls_addr, ls_wdata, 1'b1};
      end else if (g_if) begin
         {m_busy, m_ls, m_we, m_addr, m_last_ls} = {3'b100, if_addr, 1'b0};
      end
   endtask
   task automatic drive(bit r, bit ir, bit lr, bit we, bit rdy,
                        logic [AW-1:0] ia, logic [AW-1:0] la, logic [DW-1:0] wd);
      @(negedge clk);
      model_update();
      {rst, if_req, ls_req, ls_we, mem_ready} = {r, ir, lr, we, rdy};
      if_addr   = ia;
      ls_addr   = la;
      ls_wdata  = wd;
      mem_rdata = $urandom;
      #1;
      model_check();
   endtask
   typedef struct {
      bit       r, ir, lr, we, rdy;
      bit [7:0] exp;
   } vec_t;
   vec_t          tbl[12];
   logic [DW-1:0] saved;
   bit            grants[$];
   bit            exp_g[4];
   initial begin
      m_busy = 0; m_ls = 0; m_we = 0; m_irv = 0; m_lrv = 0; m_last_ls = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      // exp = {if_gnt, ls_gnt, mem_en, mem_we, addr_sel, if_rvalid, ls_rvalid, stall_if}
      tbl[0]  = '{1, 0, 0, 0, 0, 8'b0000_0000};
      tbl[1]  = '{0, 0, 0, 0, 1, 8'b0000_0000};
      tbl[2]  = '{0, 0, 0, 0, 0, 8'b0000_0000};
      tbl[3]  = '{0, 1, 0, 0, 0, 8'b1000_0000};
      tbl[4]  = '{0, 0, 0, 0, 1, 8'b0010_0000};
      tbl[5]  = '{0, 0, 0, 0, 0, 8'b0000_0100};
      tbl[6]  = '{0, 1, 1, 0, 0, 8'b0100_0001};
      tbl[7]  = '{0, 1, 0, 0, 0, 8'b0010_1001};
      tbl[8]  = '{0, 1, 0, 0, 1, 8'b0010_1001};
      tbl[9]  = '{0, 1, 0, 0, 0, 8'b1000_0010};
      tbl[10] = '{0, 0, 0, 0, 1, 8'b0010_0000};
      tbl[11] = '{0, 0, 0, 0, 0, 8'b0000_0100};
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].r, tbl[i].ir, tbl[i].lr, tbl[i].we, tbl[i].rdy, 32'h100, 32'h2000, 32'h0);
         chk($sformatf("vec%0d", i),
             {if_gnt, ls_gnt, mem_en, mem_we, addr_sel, if_rvalid, ls_rvalid, stall_if}, tbl[i].exp);
         if (i == 4) begin
            chk("fetch_addr", mem_addr, 32'h100);
            saved = mem_rdata;
         end
         if (i == 5) chk("fetch_rdata", if_rdata, saved);
         if (i == 7) chk("ls_addr", mem_addr, 32'h2000);
      end
      // store held for three wait states, then acked with zero read data
      drive(0, 0, 1, 1, 0, 32'h0, 32'h3000, 32'hDEADBEEF);
      chk("st_gnt", ls_gnt, 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 1, 0, k == 3, 32'h0, $urandom, $urandom);
         chk("st_we", mem_we, 1'b1);
         chk("st_wdata", mem_wdata, 32'hDEADBEEF);
         chk("st_addr", mem_addr, 32'h3000);
      end
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("st_ack", ls_rvalid, 1'b1);
      chk("st_rdata", ls_rdata, 32'h0);
      // reset in the second LS_BUSY cycle abandons the load
      drive(0, 0, 1, 0, 0, 32'h0, 32'h4000, 32'h0);
      chk("rs_gnt", ls_gnt, 1'b1);
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      drive(1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
      chk("rs_busy", mem_en, 1'b1);
      drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
      chk("rs_idle", mem_en, 1'b0);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
         chk("rs_no_rvalid", ls_rvalid, 1'b0);
      end
      // simultaneous requests held across four accesses
      drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      exp_g = RR_ON ? '{1, 0, 1, 0} : '{1, 1, 1, 1};
      for (int k = 0; k < 20 && grants.size() < 4; k++) begin
         drive(0, 1, 1, 0, 1, 32'h500, 32'h6000, 32'h0);
         if (ls_gnt || if_gnt) grants.push_back(ls_gnt);
      end
      chk("tie_count", grants.size(), 4);
      for (int k = 0; k < 4 && k < grants.size(); k++) chk($sformatf("tie%0d", k), grants[k], exp_g[k]);
      // random traffic against the model
      for (int k = 0; k < 600; k++)
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom, $urandom, $urandom);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
